// File: rtl/bcd_digit_entry.sv
// bcd_digit_entry: keypad digit accumulator producing a packed BCD operand
// with clear, backspace and enter, committed via a one-cycle number_valid pulse.
module bcd_digit_entry #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  key_press,
   input  logic [3:0]            key_code,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [2:0]            digit_count,
   output logic                  number_valid,
   output logic                  full_err
);
   localparam int W = 4 * DIGITS;
   localparam logic [2:0] CMAX = 3'(DIGITS);
   typedef enum logic {ENTRY, DONE} state_t;
   state_t state_q, state_d;
   logic [W-1:0] bcd_q, bcd_d;
   logic [2:0] cnt_q, cnt_d;
   logic nv_q, nv_d, fe_q, fe_d, key_prev_q;
   logic ev;
   assign ev = key_press & ~key_prev_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ENTRY;
         bcd_q      <= '0;
         cnt_q      <= '0;
         nv_q       <= 1'b0;
         fe_q       <= 1'b0;
         key_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         nv_q       <= nv_d;
         fe_q       <= fe_d;
         key_prev_q <= key_press;
      end
   end
   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      nv_d    = 1'b0;
      fe_d    = 1'b0;
      if (ev) begin
         if (key_code <= 4'd9) begin
            // a digit after a commit starts a fresh operand
            if (state_q == DONE) begin
               bcd_d   = W'(key_code);
               cnt_d   = (key_code == 4'd0) ? 3'd0 : 3'd1;
               state_d = ENTRY;
            end else if (cnt_q == CMAX) begin
               fe_d = 1'b1;
            end else if (cnt_q != 3'd0 || key_code != 4'd0) begin
               bcd_d = {bcd_q[W-5:0], key_code};
               cnt_d = cnt_q + 3'd1;
            end
         end else if (key_code == 4'hA) begin
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = ENTRY;
         end else if (key_code == 4'hB) begin
            if (state_q == ENTRY && cnt_q != 3'd0) begin
               bcd_d = bcd_q >> 4;
               cnt_d = cnt_q - 3'd1;
            end
         end else if (key_code == 4'hC) begin
            nv_d    = 1'b1;
            state_d = DONE;
         end
      end
   end
   assign bcd          = bcd_q;
   assign digit_count  = cnt_q;
   assign number_valid = nv_q;
   assign full_err     = fe_q;
endmodule

// File: doc/bcd_digit_entry.md
Name: bcd_digit_entry

Overview:
- Keypad-side digit accumulator for the calculator datapath.
- Collects decimal key presses into a packed BCD operand, supports clear, backspace and enter, and holds the result stable.
- Its bcd output feeds the BCD-to-binary converter directly.
- The number_valid pulse tells the operand/ALU control that the held value is committed.

Parameters:
- DIGITS, 4, number of BCD digits held; bcd width is 4*DIGITS (default 16 bits, max value 9999).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- key_press  input  1  level from the keypad scanner; high while a key is held. The block acts only on its rising edge.
- key_code  input  4  code of the held key, stable while key_press is high. 0-9 = digit, 4'hA = CLEAR, 4'hB = BACKSPACE, 4'hC = ENTER, 4'hD-4'hF = ignored.
- bcd  output  4*DIGITS  packed BCD operand; digit 0 in bits [3:0]. Feeds the BCD-to-binary converter.
- digit_count  output  3  number of significant digits entered, 0..DIGITS.
- number_valid  output  1  one-cycle pulse when ENTER commits the operand.
- full_err  output  1  one-cycle pulse when a digit is rejected because the buffer is full.

Behaviour:
- Registered outputs. On rst high at a clock edge:
  - bcd = 0, digit_count = 0, number_valid = 0, full_err = 0.
  - key_prev = 0, state = ENTRY.
- Reset takes priority over any key event in the same cycle. Reset mid-entry discards the partial operand.
- Edge detect: key_prev registers key_press every cycle. A key event is key_press & ~key_prev.
  - The action is applied at the same clock edge, so new outputs are visible one cycle after key_press is first sampled high.
  - Holding the key produces no repeat.
  - A release followed by a re-press produces a new event.
- States: ENTRY (collecting digits) and DONE (operand committed and held).
- Digit d in ENTRY:
  - If digit_count == DIGITS: no change; full_err pulses for one cycle.
  - Else if digit_count == 0 and d == 0: leading zero is suppressed; bcd stays 0 and digit_count stays 0.
  - Else: bcd <= {bcd[4*DIGITS-5:0], d} (shift left one digit, new digit enters the LSB); digit_count += 1.
- Digit d in DONE: start a new operand.
  - bcd <= {0, d}; digit_count <= (d == 0) ? 0 : 1; state -> ENTRY.
- BACKSPACE:
  - In ENTRY with digit_count > 0: bcd <= bcd >> 4 (zero fill at the top); digit_count -= 1.
  - In ENTRY with digit_count == 0: no-op.
  - In DONE: no-op, and the operand stays held.
- CLEAR, any state: bcd <= 0, digit_count <= 0, state -> ENTRY. No pulses.
- ENTER:
  - In ENTRY: number_valid pulses for one cycle; bcd and digit_count are held; state -> DONE.
  - ENTER with digit_count == 0 is legal and commits the value 0.
  - In DONE: number_valid pulses again with the same bcd (re-commit).
- Ignored codes (4'hD-4'hF): no state or output change.
- number_valid and full_err are never high together. Each is high for exactly one cycle per event and 0 otherwise.
- bcd only ever holds digits 0-9 in every nibble. Any key_code 0-9 is written verbatim; no other source writes nibbles.
- bcd changes only on key events or reset, so the downstream converter sees a stable value between events.

Test Plan:
- rst, then press 1,2,3,4 then ENTER (each press 2 cycles high, 2 low) -> bcd = 16'h1234, digit_count = 4; number_valid is a single 1-cycle pulse after ENTER; downstream binary reads 1234.
- After 1234, press 5 -> full_err 1-cycle pulse, bcd stays 16'h1234; then BACKSPACE twice -> bcd = 16'h0012, digit_count = 2.
- Press 0,0,7 then ENTER -> bcd = 16'h0007, digit_count = 1 (leading zeros suppressed); then press 9 from DONE -> bcd = 16'h0009, digit_count = 1, state ENTRY.
- Hold key_press high with code 5 for 10 cycles -> exactly one digit accepted (bcd = 16'h0005); release and press again -> bcd = 16'h0055.
- Enter 98, assert rst for one cycle coincident with a CLEAR or ENTER edge -> all outputs 0, no number_valid pulse; then ENTER alone -> number_valid pulse with bcd = 0.
- Ignored code 4'hE pressed mid-entry, and BACKSPACE with digit_count 0 -> no output change, no pulses.
